// File: rtl/duft_ctrl_pkg.sv
// Shared definitions for the DUFT ap_ctrl_chain burst wrapper.
//   state_t     : controller states (IDLE=0, RUN=1, DONE=2)
//   addr_idle() : all-ones "no access" sentinel for a given address width
//   beat_count(): burst length to beat count (a length of 0 means 1 beat)
package duft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returned 64 bits wide; callers cast down to their own ADDR_W.
    function automatic logic [63:0] addr_idle(input int unsigned w);
        return ~64'd0 >> (64 - w);
    endfunction

    function automatic int unsigned beat_count(input int unsigned len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/duft_beat_addr_gen.sv
// Beat address generator for one burst.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture base_in/len_in and restart at beat 0
//   step       : advance to the next beat
//   base_in    : burst base address
//   len_in     : burst length (0 treated as 1)
//   beat_addr  : base + beat*ADDR_STRIDE, wrapping at 2^ADDR_W
//   last       : current beat is the final beat of the burst
module duft_beat_addr_gen
    import duft_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 8,
    parameter int ADDR_STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ADDR_IDLE = ADDR_W'(addr_idle(ADDR_W));

    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  last_idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= ADDR_IDLE;
            cnt_q      <= '0;
            last_idx_q <= '0;
        end else if (load) begin
            base_q     <= base_in;
            cnt_q      <= '0;
            last_idx_q <= LEN_W'(beat_count(32'(len_in)) - 32'd1);
        end else if (step) begin
            cnt_q      <= cnt_q + 1'b1;
        end
    end

    assign beat_addr = base_q + ADDR_W'(cnt_q) * ADDR_W'(ADDR_STRIDE);
    assign last      = (cnt_q == last_idx_q);

endmodule

// File: rtl/duft_ap_ctrl_chain_burst.sv
// ap_ctrl_chain burst wrapper in front of the DUFT core address/message port.
//   ap_clk, ap_rst          : clock, asynchronous active-high reset
//   addr, rd_wr, len        : job descriptor, captured when ap_ready=1
//   wr_data, wr_data_vld    : write beat data; wr_data_rdy flags consumption
//   ap_start/ap_ready       : job request / job accepted
//   ap_done/ap_continue     : job complete (held) / acknowledge
//   ap_ce                   : enables beat issue only
//   ap_idle                 : no job pending or requested
//   ap_return/ap_return_vld : registered read beat data and its strobe
//   core_rd_addr/_wr_addr   : core addresses, all-ones when no access
//   core_wr_msg/core_rd_msg : core write data / combinational read data
// Optional: define DUFT_SENTINEL_CHK_EN to add ap_err, which flags a fired
// beat whose address equals the all-ones sentinel.
module duft_ap_ctrl_chain_burst
    import duft_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 8,
    parameter int ADDR_STRIDE = 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_wr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_data_vld,
    output logic              wr_data_rdy,
    input  logic              ap_start,
    input  logic              ap_continue,
    input  logic              ap_ce,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic              ap_done,
    output logic [DATA_W-1:0] ap_return,
    output logic              ap_return_vld,
    output logic [ADDR_W-1:0] core_rd_addr,
    output logic [ADDR_W-1:0] core_wr_addr,
    output logic [DATA_W-1:0] core_wr_msg,
    input  logic [DATA_W-1:0] core_rd_msg
`ifdef DUFT_SENTINEL_CHK_EN
    ,
    output logic              ap_err
`endif
);

    localparam logic [ADDR_W-1:0] ADDR_IDLE = ADDR_W'(addr_idle(ADDR_W));

    state_t            state_q, state_d;
    logic              mode_rd_q;
    logic              beat_fire;
    logic              beat_last;
    logic [ADDR_W-1:0] beat_addr;

    duft_beat_addr_gen #(
        .ADDR_W      (ADDR_W),
        .LEN_W       (LEN_W),
        .ADDR_STRIDE (ADDR_STRIDE)
    ) u_addr_gen (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .load      (ap_ready),
        .step      (beat_fire),
        .base_in   (addr),
        .len_in    (len),
        .beat_addr (beat_addr),
        .last      (beat_last)
    );

    assign beat_fire   = (state_q == RUN) && ap_ce && (mode_rd_q || wr_data_vld);
    assign wr_data_rdy = beat_fire && !mode_rd_q;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ap_idle  = 1'b0;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        case (state_q)
            IDLE: begin
                ap_idle = !ap_start;
                if (ap_start) begin
                    ap_ready = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (beat_fire && beat_last) state_d = DONE;
            end
            DONE: begin
                ap_done = 1'b1;
                // Chaining: a new job is taken in the same cycle done is consumed.
                if (ap_continue) begin
                    if (ap_start) begin
                        ap_ready = 1'b1;
                        state_d  = RUN;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_rd_addr = ADDR_IDLE;
        core_wr_addr = ADDR_IDLE;
        core_wr_msg  = '0;
        if (beat_fire) begin
            if (mode_rd_q) begin
                core_rd_addr = beat_addr;
            end else begin
                core_wr_addr = beat_addr;
                core_wr_msg  = wr_data;
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            mode_rd_q     <= 1'b0;
            ap_return     <= '0;
            ap_return_vld <= 1'b0;
        end else begin
            if (ap_ready) mode_rd_q <= rd_wr;
            ap_return_vld <= beat_fire && mode_rd_q;
            if (beat_fire) begin
                if (mode_rd_q)      ap_return <= core_rd_msg;
                else if (beat_last) ap_return <= '0;
            end
        end
    end

`ifdef DUFT_SENTINEL_CHK_EN
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)                                      ap_err <= 1'b0;
        else if (ap_ready)                               ap_err <= 1'b0;
        else if (beat_fire && (beat_addr == ADDR_IDLE))  ap_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_duft_ap_ctrl_chain_burst.sv
// Self-checking bench for duft_ap_ctrl_chain_burst: a directed vector table,
// hand-written corner sequences and randomized traffic against a queue model.
module tb_duft_ap_ctrl_chain_burst;

    localparam int          STRIDE = 1;
    localparam logic [31:0] A1     = 32'hFFFF_FFFF;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [31:0] addr;
    logic        rd_wr;
    logic [7:0]  len;
    logic [31:0] wr_data;
    logic        wr_data_vld;
    logic        wr_data_rdy;
    logic        ap_start;
    logic        ap_continue;
    logic        ap_ce;
    logic        ap_idle;
    logic        ap_ready;
    logic        ap_done;
    logic [31:0] ap_return;
    logic        ap_return_vld;
    logic [31:0] core_rd_addr;
    logic [31:0] core_wr_addr;
    logic [31:0] core_wr_msg;
    logic [31:0] core_rd_msg;
`ifdef DUFT_SENTINEL_CHK_EN
    logic        ap_err;
`endif

    bit use_fn;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // Core model: read data is a combinational function of the address.
    assign core_rd_msg = use_fn ? rd_fn(core_rd_addr) : 32'h0000_A5A5;

    always #5 ap_clk = ~ap_clk;

    duft_ap_ctrl_chain_burst #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .LEN_W       (8),
        .ADDR_STRIDE (STRIDE)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .addr          (addr),
        .rd_wr         (rd_wr),
        .len           (len),
        .wr_data       (wr_data),
        .wr_data_vld   (wr_data_vld),
        .wr_data_rdy   (wr_data_rdy),
        .ap_start      (ap_start),
        .ap_continue   (ap_continue),
        .ap_ce         (ap_ce),
        .ap_idle       (ap_idle),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .ap_return     (ap_return),
        .ap_return_vld (ap_return_vld),
        .core_rd_addr  (core_rd_addr),
        .core_wr_addr  (core_wr_addr),
        .core_wr_msg   (core_wr_msg),
        .core_rd_msg   (core_rd_msg)
`ifdef DUFT_SENTINEL_CHK_EN
        ,
        .ap_err        (ap_err)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // ph: 0 = no job, 1 = beats outstanding, 2 = waiting for acknowledge
    int          ph;
    logic [31:0] m_q[$];
    bit          m_rd;
    logic [31:0] m_ret;
    bit          m_vld;
    bit          m_err;

    task automatic model_reset();
        ph = 0; m_q.delete(); m_rd = 1'b0; m_ret = '0; m_vld = 1'b0; m_err = 1'b0;
    endtask

    task automatic step(input bit st, input bit ct, input bit ce, input bit vld, input bit rd,
                        input logic [31:0] a, input logic [7:0] l, input logic [31:0] wd);
        bit          fire, acc;
        int          old, n;
        logic [31:0] a0;
        @(negedge ap_clk);
        ap_start = st; ap_continue = ct; ap_ce = ce; wr_data_vld = vld;
        rd_wr = rd; addr = a; len = l; wr_data = wd;
        #1;
        old  = ph;
        fire = (ph == 1) && ce && (m_rd || vld);
        acc  = (ph == 0 && st) || (ph == 2 && ct && st);
        a0   = fire ? m_q[0] : A1;
        chk("rd_addr", core_rd_addr, (fire && m_rd) ? a0 : A1);
        chk("wr_addr", core_wr_addr, (fire && !m_rd) ? a0 : A1);
        chk("wr_msg", core_wr_msg, (fire && !m_rd) ? wd : 32'd0);
        chk("wr_rdy", 32'(wr_data_rdy), 32'(fire && !m_rd));
        chk("ready", 32'(ap_ready), 32'(acc));
        chk("done", 32'(ap_done), 32'(ph == 2));
        chk("idle", 32'(ap_idle), 32'(ph == 0 && !st));
        chk("ret", ap_return, m_ret);
        chk("ret_vld", 32'(ap_return_vld), 32'(m_vld));
`ifdef DUFT_SENTINEL_CHK_EN
        chk("err", 32'(ap_err), 32'(m_err));
`endif
        m_vld = 1'b0;
        if (fire) begin
            void'(m_q.pop_front());
            if (m_rd) begin
                m_ret = rd_fn(a0);
                m_vld = 1'b1;
            end else if (m_q.size() == 0) begin
                m_ret = '0;
            end
            if (a0 == A1) m_err = 1'b1;
            if (m_q.size() == 0) ph = 2;
        end
        if (acc) begin
            n = (l == 0) ? 1 : int'(l);
            m_q.delete();
            for (int i = 0; i < n; i++) m_q.push_back(a + 32'(i) * 32'(STRIDE));
            m_rd  = rd;
            m_err = 1'b0;
            ph    = 1;
        end else if (old == 2 && ct) begin
            ph = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst = 1'b1;
        ap_start = 1'b0; ap_continue = 1'b0; wr_data_vld = 1'b0;
        #1;
        model_reset();
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] st, ct, ce, vld, rd, a, l, wd;
        logic [31:0] ra, wa, wm, rdy, dn, idl, wrdy, ret, rv;
    } vec_t;

    vec_t tbl[22];

    initial begin
        ap_rst = 1'b1; addr = '0; rd_wr = 1'b0; len = '0; wr_data = '0;
        wr_data_vld = 1'b0; ap_start = 1'b0; ap_continue = 1'b0; ap_ce = 1'b1;
        use_fn = 1'b0;
        model_reset();

        // st ct ce vld rd addr len wd | rd_addr wr_addr wr_msg ready done idle wr_rdy ret vld
        // single read at 0x20
        tbl[0]  = '{1,0,1,0,1,'h20,1,0,     A1,A1,0,       1,0,0,0, 0,0};
        tbl[1]  = '{0,0,1,0,1,'h20,1,0,     'h20,A1,0,     0,0,0,0, 0,0};
        tbl[2]  = '{0,0,1,0,1,0,0,0,        A1,A1,0,       0,1,0,0, 'hA5A5,1};
        tbl[3]  = '{0,1,1,0,1,0,0,0,        A1,A1,0,       0,1,0,0, 'hA5A5,0};
        tbl[4]  = '{0,0,1,0,1,0,0,0,        A1,A1,0,       0,0,1,0, 'hA5A5,0};
        // read burst of 4 at 0x10
        tbl[5]  = '{1,0,1,0,1,'h10,4,0,     A1,A1,0,       1,0,0,0, 'hA5A5,0};
        tbl[6]  = '{0,0,1,0,1,0,0,0,        'h10,A1,0,     0,0,0,0, 'hA5A5,0};
        tbl[7]  = '{0,0,1,0,1,0,0,0,        'h11,A1,0,     0,0,0,0, 'hA5A5,1};
        tbl[8]  = '{0,0,1,0,1,0,0,0,        'h12,A1,0,     0,0,0,0, 'hA5A5,1};
        tbl[9]  = '{0,0,1,0,1,0,0,0,        'h13,A1,0,     0,0,0,0, 'hA5A5,1};
        tbl[10] = '{0,0,1,0,1,0,0,0,        A1,A1,0,       0,1,0,0, 'hA5A5,1};
        tbl[11] = '{0,1,1,0,1,0,0,0,        A1,A1,0,       0,1,0,0, 'hA5A5,0};
        // write burst of 3 at 0x40 with data valid 1,0,1,1
        tbl[12] = '{1,0,1,0,0,'h40,3,0,     A1,A1,0,       1,0,0,0, 'hA5A5,0};
        tbl[13] = '{0,0,1,1,0,0,0,'hD1,     A1,'h40,'hD1,  0,0,0,1, 'hA5A5,0};
        tbl[14] = '{0,0,1,0,0,0,0,'hD2,     A1,A1,0,       0,0,0,0, 'hA5A5,0};
        tbl[15] = '{0,0,1,1,0,0,0,'hD3,     A1,'h41,'hD3,  0,0,0,1, 'hA5A5,0};
        tbl[16] = '{0,0,1,1,0,0,0,'hD4,     A1,'h42,'hD4,  0,0,0,1, 'hA5A5,0};
        // chained read of 2 at 0x80 accepted while done is consumed
        tbl[17] = '{1,1,1,0,1,'h80,2,0,     A1,A1,0,       1,1,0,0, 0,0};
        tbl[18] = '{0,0,1,0,1,0,0,0,        'h80,A1,0,     0,0,0,0, 0,0};
        tbl[19] = '{0,0,1,0,1,0,0,0,        'h81,A1,0,     0,0,0,0, 'hA5A5,1};
        tbl[20] = '{0,1,1,0,1,0,0,0,        A1,A1,0,       0,1,0,0, 'hA5A5,1};
        tbl[21] = '{0,0,1,0,1,0,0,0,        A1,A1,0,       0,0,1,0, 'hA5A5,0};

        // reset state
        repeat (2) @(negedge ap_clk);
        #1;
        chk("rst idle", 32'(ap_idle), 32'd1);
        chk("rst done", 32'(ap_done), 32'd0);
        chk("rst ready", 32'(ap_ready), 32'd0);
        chk("rst rd_addr", core_rd_addr, A1);
        chk("rst wr_addr", core_wr_addr, A1);
        chk("rst ret", ap_return, 32'd0);
        chk("rst ret_vld", 32'(ap_return_vld), 32'd0);
`ifdef DUFT_SENTINEL_CHK_EN
        chk("rst err", 32'(ap_err), 32'd0);
`endif
        @(negedge ap_clk);
        ap_rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            @(negedge ap_clk);
            ap_start = tbl[i].st[0]; ap_continue = tbl[i].ct[0]; ap_ce = tbl[i].ce[0];
            wr_data_vld = tbl[i].vld[0]; rd_wr = tbl[i].rd[0]; addr = tbl[i].a;
            len = tbl[i].l[7:0]; wr_data = tbl[i].wd;
            #1;
            chk($sformatf("tbl%0d rd_addr", i), core_rd_addr, tbl[i].ra);
            chk($sformatf("tbl%0d wr_addr", i), core_wr_addr, tbl[i].wa);
            chk($sformatf("tbl%0d wr_msg", i), core_wr_msg, tbl[i].wm);
            chk($sformatf("tbl%0d ready", i), 32'(ap_ready), tbl[i].rdy);
            chk($sformatf("tbl%0d done", i), 32'(ap_done), tbl[i].dn);
            chk($sformatf("tbl%0d idle", i), 32'(ap_idle), tbl[i].idl);
            chk($sformatf("tbl%0d wr_rdy", i), 32'(wr_data_rdy), tbl[i].wrdy);
            chk($sformatf("tbl%0d ret", i), ap_return, tbl[i].ret);
            chk($sformatf("tbl%0d ret_vld", i), 32'(ap_return_vld), tbl[i].rv);
        end

        use_fn = 1'b1;
        do_reset();

        // ap_ce dropped for two cycles mid read burst, then reset mid-burst
        step(1, 0, 1, 0, 1, 32'h100, 8'd4, 0);
        step(0, 0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0, 0);
        @(negedge ap_clk);
        ap_rst = 1'b1; ap_start = 1'b0; ap_ce = 1'b1;
        #1;
        chk("midrst rd_addr", core_rd_addr, A1);
        chk("midrst ret", ap_return, 32'd0);
        chk("midrst ret_vld", 32'(ap_return_vld), 32'd0);
        chk("midrst done", 32'(ap_done), 32'd0);
        model_reset();
        @(negedge ap_clk);
        ap_rst = 1'b0;
        repeat (3) step(0, 1, 1, 0, 1, 0, 0, 0);

        // wrap through the sentinel address, then chain a new job
        step(1, 0, 1, 0, 1, 32'hFFFF_FFFE, 8'd3, 0);
        repeat (3) step(0, 0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 32'h200, 8'd0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 32'hCAFE_0001);
        step(0, 1, 1, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'hFFFF)),
                 8'($urandom_range(0, 5)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
